// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-line bundle for seq_frame_tx.
// The master side requests frames; the slave side is the transmitter.
interface seq_frame_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 start;
    logic [PAYLOAD_W-1:0] data_in;
    logic                 tx_bit;
    logic                 tx_valid;
    logic                 busy;
    logic                 done;

    modport master (
        output start, data_in,
        input  tx_bit, tx_valid, busy, done
    );

    modport slave (
        input  start, data_in,
        output tx_bit, tx_valid, busy, done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word 1011, payload MSB-first, one guard 0.
// Every output is a flop, so the line can feed a Moore sequence detector directly.
module seq_frame_tx #(
    parameter int         PAYLOAD_W = 8,
    parameter logic [3:0] SYNC      = 4'b1011
) (
    input  logic          clk,
    input  logic          rst,
    seq_frame_tx_if.slave bus
);
    localparam int               CNT_W     = $clog2((PAYLOAD_W > 4) ? PAYLOAD_W : 4) + 1;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SYNC    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_GUARD   = 2'd3
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic [PAYLOAD_W-1:0] r_shift,  w_shift_nxt;
    logic [3:0]           r_sync,   w_sync_nxt;
    logic                 r_tx_bit, w_tx_bit_nxt;
    logic                 r_tx_valid, w_tx_valid_nxt;
    logic                 r_busy,   w_busy_nxt;
    logic                 r_done,   w_done_nxt;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_sync_nxt  = r_sync;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SYNC;
                    w_shift_nxt = bus.data_in;
                    w_sync_nxt  = SYNC;
                    w_cnt_nxt   = '0;
                end
            end
            S_SYNC: begin
                w_sync_nxt = r_sync << 1;
                if (r_cnt == SYNC_LAST) begin
                    w_state_nxt = S_PAYLOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PAYLOAD: begin
                w_shift_nxt = r_shift << 1;
                if (r_cnt == PAY_LAST) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GUARD: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops with the state itself.
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_tx_valid_nxt = (w_state_nxt == S_SYNC) || (w_state_nxt == S_PAYLOAD);
        w_done_nxt     = (w_state_nxt == S_GUARD);
        w_tx_bit_nxt   = 1'b0;
        if (w_state_nxt == S_SYNC) begin
            w_tx_bit_nxt = w_sync_nxt[3];
        end else if (w_state_nxt == S_PAYLOAD) begin
            w_tx_bit_nxt = w_shift_nxt[PAYLOAD_W-1];
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_sync     <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_sync     <= w_sync_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.tx_bit   = r_tx_bit;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx at PAYLOAD_W = 8, 1 and 32, run side by side.
// A queue-based frame model predicts {tx_bit, tx_valid, busy, done} every cycle.
module tb_seq_frame_tx;
    localparam logic [3:0] SYNC_WORD = 4'b1011;

    logic        clk;
    logic        rst;
    logic        st  [3];
    logic [31:0] din [3];
    logic [3:0]  obs [3];
    logic [3:0]  exp_o [3];

    int n_checks = 0;
    int n_pass   = 0;

    seq_frame_tx_if #(.PAYLOAD_W(8))  if_w8  ();
    seq_frame_tx_if #(.PAYLOAD_W(1))  if_w1  ();
    seq_frame_tx_if #(.PAYLOAD_W(32)) if_w32 ();

    seq_frame_tx #(.PAYLOAD_W(8))  u_dut_w8  (.clk(clk), .rst(rst), .bus(if_w8.slave));
    seq_frame_tx #(.PAYLOAD_W(1))  u_dut_w1  (.clk(clk), .rst(rst), .bus(if_w1.slave));
    seq_frame_tx #(.PAYLOAD_W(32)) u_dut_w32 (.clk(clk), .rst(rst), .bus(if_w32.slave));

    assign if_w8.start    = st[0];
    assign if_w8.data_in  = din[0][7:0];
    assign if_w1.start    = st[1];
    assign if_w1.data_in  = din[1][0:0];
    assign if_w32.start   = st[2];
    assign if_w32.data_in = din[2];

    assign obs[0] = {if_w8.tx_bit,  if_w8.tx_valid,  if_w8.busy,  if_w8.done};
    assign obs[1] = {if_w1.tx_bit,  if_w1.tx_valid,  if_w1.busy,  if_w1.done};
    assign obs[2] = {if_w32.tx_bit, if_w32.tx_valid, if_w32.busy, if_w32.done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: an accepted start queues the whole frame's per-cycle outputs.
    for (genvar g = 0; g < 3; g++) begin : g_model
        localparam int WG = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
        logic [3:0] q [$];
        logic [3:0] cur_g = 4'b0;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                q.delete();
                cur_g <= 4'b0;
            end else begin
                if (q.size() == 0 && !cur_g[1] && st[g]) begin
                    for (int b = 3; b >= 0; b--) q.push_back({SYNC_WORD[b], 3'b110});
                    for (int b = WG - 1; b >= 0; b--) q.push_back({din[g][b], 3'b110});
                    q.push_back(4'b0011);
                end
                if (q.size() != 0) cur_g <= q.pop_front();
                else               cur_g <= 4'b0;
            end
        end

        assign exp_o[g] = cur_g;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cycle_w%0d", (i == 0) ? 8 : ((i == 1) ? 1 : 32)),
                  {28'd0, obs[i]}, {28'd0, exp_o[i]});
        end
    end

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) st[i] = 1'b0;
        end
    endtask

    initial begin
        logic [11:0] bits;
        logic [3:0]  hist;
        int          busy_cnt;
        int          done_cnt;
        int          det_cnt;
        int          busy_w1;
        int          busy_w32;
        int          done_w1;
        int          done_w32;
        logic [31:0] pats [3];

        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            din[i] = '0;
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check("reset_outputs", {28'd0, obs[i]}, 32'd0);

        // Reset then idle
        idle_cycles(3);
        rst = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_w8.busy || if_w8.tx_valid || if_w8.tx_bit || if_w8.done) busy_cnt++;
        end
        check("idle_quiet", busy_cnt, 0);

        // Single A5 frame with ignored starts at E+3 and at the GUARD edge
        @(negedge clk);
        st[0] = 1'b1; din[0] = 32'hA5;
        bits = '0; busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k < 12) bits[11-k] = if_w8.tx_bit;
            if (if_w8.busy) busy_cnt++;
            if (if_w8.done) done_cnt++;
            st[0]  = (k == 2) || (k == 12);
            din[0] = ((k == 2) || (k == 12)) ? 32'hFF : 32'hA5;
        end
        st[0] = 1'b0;
        check("a5_bits", {20'd0, bits}, 32'h0000_0BA5);
        check("a5_busy_cycles", busy_cnt, 13);
        check("a5_done_pulses", done_cnt, 1);

        // Back-to-back frames with start held high and a zero payload
        idle_cycles(5);
        st[0] = 1'b1; din[0] = 32'h0;
        hist = '0; done_cnt = 0; det_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (if_w8.done) done_cnt++;
            if (if_w8.busy) busy_cnt++;
            hist = {hist[2:0], if_w8.tx_bit};
            if (hist == 4'b1011) begin
                det_cnt++;
                hist = '0;
            end
        end
        st[0] = 1'b0;
        check("b2b_done", done_cnt, 3);
        check("b2b_busy", busy_cnt, 39);
        check("b2b_detect", det_cnt, 3);

        // Asynchronous reset during payload, then a fresh 3C frame
        idle_cycles(5);
        st[0] = 1'b1; din[0] = $urandom();
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_valid", {31'd0, if_w8.tx_valid}, 32'd1);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check("async_reset", {28'd0, obs[i]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        st[0] = 1'b1; din[0] = 32'h3C;
        bits = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            st[0] = 1'b0;
            if (k < 12) bits[11-k] = if_w8.tx_bit;
        end
        check("post_reset_3c", {20'd0, bits}, 32'h0000_0B3C);

        // Width sweep: alternating and all-ones payloads on W=1 and W=32
        pats[0] = 32'hAAAA_AAAA;
        pats[1] = 32'hFFFF_FFFF;
        pats[2] = 32'h5555_5555;
        for (int p = 0; p < 3; p++) begin
            idle_cycles(2);
            st[1] = 1'b1; din[1] = pats[p];
            st[2] = 1'b1; din[2] = pats[p];
            busy_w1 = 0; busy_w32 = 0; done_w1 = 0; done_w32 = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                st[1] = 1'b0; st[2] = 1'b0;
                if (if_w1.busy)  busy_w1++;
                if (if_w32.busy) busy_w32++;
                if (if_w1.done)  done_w1++;
                if (if_w32.done) done_w32++;
            end
            check("w1_busy",  busy_w1,  6);
            check("w32_busy", busy_w32, 37);
            check("w1_done",  done_w1,  1);
            check("w32_done", done_w32, 1);
        end

        // Randomized requests and payloads on all three widths
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                st[i]  = ($urandom_range(0, 3) == 0);
                din[i] = $urandom();
            end
        end
        idle_cycles(45);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
